// File: rtl/tjmono_data_tx_if.sv
// Hit-injection and token/read/freeze signals between the TJ-Monopix
// readout emulator (slave) and whatever drives it (master).
interface tjmono_data_tx_if;
    logic       HIT_WR;
    logic [5:0] HIT_COL;
    logic [8:0] HIT_ROW;
    logic [5:0] HIT_LE;
    logic [5:0] HIT_TE;
    logic       HIT_FULL;
    logic       READ;
    logic       FREEZE;
    logic       TOKEN;
    logic       DATA;
    logic       BUSY;
    logic [7:0] LOST_CNT;
    logic [7:0] READ_ERR_CNT;

    modport master (
        output HIT_WR, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, READ, FREEZE,
        input  HIT_FULL, TOKEN, DATA, BUSY, LOST_CNT, READ_ERR_CNT
    );

    modport slave (
        input  HIT_WR, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, READ, FREEZE,
        output HIT_FULL, TOKEN, DATA, BUSY, LOST_CNT, READ_ERR_CNT
    );
endinterface

// File: rtl/tjmono_data_tx.sv
// TJ-Monopix chip-side readout emulator: buffers gray-encoded hits, raises
// TOKEN while hits are pending and serializes one 27-bit word per READ edge.
module tjmono_data_tx #(
    parameter int DEPTH_LOG2   = 4,
    parameter int READ_LATENCY = 3
) (
    input logic            CLK,
    input logic            RST_N,
    tjmono_data_tx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_e;

    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [3:0]          LAT     = 4'(READ_LATENCY);

    function automatic logic [5:0] gray6(input logic [5:0] x);
        return x ^ (x >> 1);
    endfunction

    logic [26:0]         mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q, frz_cnt_q, occ;
    logic                read_q, freeze_q, token_q;
    logic [7:0]          lost_q, rerr_q;
    state_e              state_q;
    logic [3:0]          wait_q;
    logic [4:0]          bit_q;
    logic [26:0]         sh_q;
    logic                data_q, busy_q;

    logic        full, empty, push, read_edge, frz_edge, accept;
    logic [26:0] word_in, pop_word;

    assign occ       = wr_ptr_q - rd_ptr_q;
    assign full      = (occ == DEPTH_W);
    assign empty     = (occ == '0);
    assign push      = bus.HIT_WR && !full;
    assign read_edge = bus.READ && !read_q;
    assign frz_edge  = bus.FREEZE && !freeze_q;
    assign accept    = read_edge && (state_q == IDLE) && !empty &&
                       (!bus.FREEZE || (frz_cnt_q != '0));
    assign word_in   = {bus.HIT_COL, gray6(bus.HIT_TE), gray6(bus.HIT_LE), bus.HIT_ROW};
    assign pop_word  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // NOTE: the hit storage has no reset; an empty FIFO is defined by the pointers alone.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= word_in;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            frz_cnt_q <= '0;
            read_q    <= 1'b0;
            freeze_q  <= 1'b0;
            token_q   <= 1'b0;
            lost_q    <= '0;
            rerr_q    <= '0;
        end else begin
            read_q   <= bus.READ;
            freeze_q <= bus.FREEZE;
            token_q  <= bus.FREEZE ? (frz_cnt_q != '0) : !empty;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (accept) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (bus.HIT_WR && full && lost_q != 8'hFF) lost_q <= lost_q + 8'd1;
            if (read_edge && !accept && rerr_q != 8'hFF) rerr_q <= rerr_q + 8'd1;
            // The frozen set counts what remains after this cycle's pop, never this cycle's push.
            if (frz_edge)
                frz_cnt_q <= occ - {{DEPTH_LOG2{1'b0}}, accept};
            else if (accept && bus.FREEZE)
                frz_cnt_q <= frz_cnt_q - PTR_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            wait_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (LAT == 4'd0) begin
                            state_q <= SHIFT;
                            data_q  <= pop_word[26];
                            sh_q    <= {pop_word[25:0], 1'b0};
                            bit_q   <= '0;
                        end else begin
                            state_q <= WAIT;
                            sh_q    <= pop_word;
                            wait_q  <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (wait_q == LAT - 4'd1) begin
                        state_q <= SHIFT;
                        data_q  <= sh_q[26];
                        sh_q    <= {sh_q[25:0], 1'b0};
                        bit_q   <= '0;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                SHIFT: begin
                    if (bit_q == 5'd26) begin
                        state_q <= IDLE;
                        data_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q <= sh_q[26];
                        sh_q   <= {sh_q[25:0], 1'b0};
                        bit_q  <= bit_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.HIT_FULL     = full;
    assign bus.TOKEN        = token_q;
    assign bus.DATA         = data_q;
    assign bus.BUSY         = busy_q;
    assign bus.LOST_CNT     = lost_q;
    assign bus.READ_ERR_CNT = rerr_q;

endmodule

// File: tb/tb_tjmono_data_tx.sv
// Scoreboard bench for tjmono_data_tx: a queue-based reference model predicts
// accepted words, TOKEN, HIT_FULL and counters; a monitor deserializes DATA.
module tb_tjmono_data_tx;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
    localparam int LAT   = 3;

    typedef struct {
        logic [26:0] w;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tjmono_data_tx_if bus();

    tjmono_data_tx #(.DEPTH_LOG2(DL2), .READ_LATENCY(LAT)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [26:0] mq[$];
    exp_t        sb[$];
    int          frz = 0, lost = 0, rerr = 0, busy_left = 0;
    bit          rd_prev = 0, fz_prev = 0, tok_m = 0;
    int          mon_p = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] encode(logic [5:0] col, logic [8:0] row,
                                           logic [5:0] le, logic [5:0] te);
        logic [5:0] gte, gle;
        gte = te ^ (te >> 1);
        gle = le ^ (le >> 1);
        return {col, gte, gle, row};
    endfunction

    task automatic model_edge();
        bit   edge_r, fz, acc;
        int   sz;
        exp_t e;
        edge_r = bus.READ && !rd_prev;
        fz     = bus.FREEZE;
        sz     = mq.size();
        acc    = edge_r && busy_left == 0 && sz > 0 && (!fz || frz != 0);
        tok_m  = fz ? (frz != 0) : (sz != 0);
        if (acc) begin
            e.w = mq.pop_front();
            e.c = cyc;
            sb.push_back(e);
        end else if (edge_r && rerr < 255) begin
            rerr++;
        end
        if (bus.HIT_WR) begin
            if (sz == DEPTH) begin
                if (lost < 255) lost++;
            end else begin
                mq.push_back(encode(bus.HIT_COL, bus.HIT_ROW, bus.HIT_LE, bus.HIT_TE));
            end
        end
        if (fz && !fz_prev) frz = sz - int'(acc);
        else if (acc && fz) frz--;
        busy_left = acc ? 27 + LAT : (busy_left > 0 ? busy_left - 1 : 0);
        rd_prev = bus.READ;
        fz_prev = fz;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        @(negedge clk);
        if (rst_n) begin
            check("token", bus.TOKEN, 32'(tok_m));
            check("hit_full", bus.HIT_FULL, 32'(mq.size() == DEPTH));
            check("lost_cnt", bus.LOST_CNT, lost);
            check("read_err_cnt", bus.READ_ERR_CNT, rerr);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [5:0] col, input logic [8:0] row,
                        input logic [5:0] le, input logic [5:0] te);
        bus.HIT_WR  = 1'b1;
        bus.HIT_COL = col;
        bus.HIT_ROW = row;
        bus.HIT_LE  = le;
        bus.HIT_TE  = te;
        tick();
        bus.HIT_WR = 1'b0;
    endtask

    task automatic push_rand();
        push(6'($urandom), 9'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic read_pulse();
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        tick();
    endtask

    // Called just after a negedge; resets asynchronously away from any edge.
    task automatic do_reset();
        bus.HIT_WR = 1'b0;
        bus.READ   = 1'b0;
        bus.FREEZE = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_data", bus.DATA, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_token", bus.TOKEN, 0);
        check("rst_full", bus.HIT_FULL, 0);
        check("rst_lost", bus.LOST_CNT, 0);
        check("rst_rerr", bus.READ_ERR_CNT, 0);
        mq.delete();
        sb.delete();
        frz = 0; lost = 0; rerr = 0; busy_left = 0;
        rd_prev = 0; fz_prev = 0; tok_m = 0;
        wait_cycles(2);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: every BUSY rise must match the oldest expected word and its timing.
    initial begin
        logic [26:0] got;
        exp_t        e;
        got = '0;
        e.w = '0;
        e.c = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_p = -1;
            end else begin
                if (mon_p < 0 && bus.BUSY) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", 1, 0);
                        e.w = '0;
                        e.c = -1;
                    end else begin
                        e = sb.pop_front();
                        check("busy_start_cycle", cyc, e.c);
                    end
                    mon_p = 0;
                    got   = '0;
                end
                if (mon_p < 0) begin
                    check("data_idle", bus.DATA, 0);
                end else if (mon_p < LAT) begin
                    check("data_wait", bus.DATA, 0);
                    check("busy_wait", bus.BUSY, 1);
                    mon_p++;
                end else if (mon_p < LAT + 27) begin
                    check("busy_shift", bus.BUSY, 1);
                    got = {got[25:0], bus.DATA};
                    if (mon_p == LAT + 26) check("word", got, 32'(e.w));
                    mon_p++;
                end else begin
                    check("busy_end", bus.BUSY, 0);
                    check("data_end", bus.DATA, 0);
                    mon_p = -1;
                end
            end
        end
    end

    initial begin
        int guard;
        bus.HIT_WR  = 1'b0;
        bus.HIT_COL = '0;
        bus.HIT_ROW = '0;
        bus.HIT_LE  = '0;
        bus.HIT_TE  = '0;
        bus.READ    = 1'b0;
        bus.FREEZE  = 1'b0;
        wait_cycles(2);
        do_reset();
        wait_cycles(2);

        // Single known hit.
        push(6'd5, 9'd300, 6'd9, 6'd12);
        wait_cycles(2);
        read_pulse();
        wait_cycles(35);

        // Overflow: six pushes into a four-deep FIFO, then four reads.
        for (int i = 1; i <= 6; i++) push(6'(i), 9'(i * 7), 6'(i), 6'(i + 20));
        for (int i = 0; i < 4; i++) begin
            read_pulse();
            wait_cycles(32);
        end

        // Freeze set excludes hits pushed while frozen.
        do_reset();
        for (int i = 0; i < 3; i++) push_rand();
        bus.FREEZE = 1'b1;
        tick();
        push_rand();
        push_rand();
        for (int i = 0; i < 3; i++) begin
            read_pulse();
            wait_cycles(32);
        end
        read_pulse();
        bus.FREEZE = 1'b0;
        wait_cycles(4);
        read_pulse();
        wait_cycles(32);
        read_pulse();
        wait_cycles(32);

        // Empty read, then a read in the middle of a word.
        do_reset();
        read_pulse();
        push_rand();
        read_pulse();
        wait_cycles(10);
        read_pulse();
        wait_cycles(30);

        // READ held high: only its rising edge counts.
        push_rand();
        push_rand();
        bus.READ = 1'b1;
        wait_cycles(40);
        bus.READ = 1'b0;
        wait_cycles(3);
        read_pulse();
        wait_cycles(32);

        // Counter saturation.
        bus.READ = 1'b0;
        for (int i = 0; i < 260; i++) read_pulse();
        for (int i = 0; i < DEPTH; i++) push_rand();
        bus.HIT_WR = 1'b1;
        wait_cycles(262);
        bus.HIT_WR = 1'b0;
        tick();

        // Reset in the middle of a word.
        do_reset();
        push_rand();
        push_rand();
        read_pulse();
        wait_cycles(LAT + 9);
        do_reset();
        wait_cycles(3);
        read_pulse();
        wait_cycles(3);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.HIT_WR  = ($urandom_range(0, 3) == 0);
            bus.HIT_COL = 6'($urandom);
            bus.HIT_ROW = 9'($urandom);
            bus.HIT_LE  = 6'($urandom);
            bus.HIT_TE  = 6'($urandom);
            bus.READ    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) bus.FREEZE = ~bus.FREEZE;
            tick();
        end
        bus.HIT_WR = 1'b0;
        bus.READ   = 1'b0;
        bus.FREEZE = 1'b0;

        guard = 0;
        while ((sb.size() != 0 || mon_p >= 0) && guard < 300) begin
            tick();
            guard++;
        end
        check("drain_timeout", 32'(guard >= 300), 0);
        wait_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
